ibus_dbus_arbiter: RTL and testbench
====================================

Name: ibus_dbus_arbiter

Overview:
- Shares one single-port memory bus between the fetch path (ibus, read-only) and the load/store path (dbus, read/write).
- Sits between the IF stage / MEM stage and the memory or interconnect port.
- Grants the bus to one requester at a time, latches its request, waits for the memory response and routes it back.
- Provides starvation protection for fetch and a response timeout with an error pulse.

Parameters:
STARVE_MAX, 4, consecutive dbus grants allowed while ibus is pending before ibus is forced to win (1..15)
TIMEOUT, 255, cycles a granted transaction may wait for i_mem_rsp before abort (1..255)

Ports:
i_clk  input  1  clock, all state updates on posedge
i_rst_n  input  1  reset, synchronous, active-low
i_ibus_req  input  1  fetch request, held until o_ibus_rsp
i_ibus_addr  input  32  fetch address
o_ibus_data  output  32  fetch data, valid when o_ibus_rsp=1
o_ibus_rsp  output  1  fetch response pulse
i_dbus_req  input  1  load/store request, held until o_dbus_rsp
i_dbus_addr  input  32  load/store address
i_dbus_we  input  1  1=store, 0=load
i_dbus_wdata  input  32  store data
i_dbus_wmask  input  4  byte enables for store
o_dbus_rdata  output  32  load data, valid when o_dbus_rsp=1
o_dbus_rsp  output  1  load/store response pulse
o_mem_req  output  1  request to memory
o_mem_addr  output  32  latched address
o_mem_we  output  1  latched write enable (0 for ibus)
o_mem_wdata  output  32  latched store data (0 for ibus)
o_mem_wmask  output  4  latched mask (0 for ibus)
i_mem_rdata  input  32  memory read data
i_mem_rsp  input  1  memory completion, 1-cycle pulse, earliest the cycle after o_mem_req rises
o_bus_err  output  1  1-cycle pulse on timeout abort

Behaviour:
- Reset (i_rst_n=0 at posedge): state=IDLE; starve_cnt=0; tmo_cnt=0; all o_mem_* registers 0. Reset applies even mid-transaction; a later i_mem_rsp arriving in IDLE is ignored.
- States:
  - IDLE: no owner.
  - GNT_I: ibus owns the bus.
  - GNT_D: dbus owns the bus.
- Arbitration function (evaluated in IDLE, and in GNT_* on the cycle i_mem_rsp=1):
  - dbus only: dbus wins.
  - ibus only: ibus wins.
  - Both requesting: dbus wins, unless starve_cnt==STARVE_MAX, in which case ibus wins.
  - Neither requesting: go to IDLE.
- Request hand-off at completion:
  - The owner's response cycle does not count its own still-high req.
  - For re-arbitration on that edge, the completing requester's req is masked for that cycle, so it can re-win no earlier than the following arbitration.
- Grant action (registered on posedge):
  - Latch the winner's addr/we/wdata/wmask into o_mem_*; ibus grant forces we=0, wdata=0, wmask=0.
  - o_mem_req=1 from the cycle after the decision.
  - tmo_cnt=0.
- Latency: request in IDLE → o_mem_req high next cycle. Back-to-back: i_mem_rsp with a pending other requester → new grant on the next edge, zero idle cycles.
- o_mem_req stays 1 in GNT_* until the i_mem_rsp edge; it is 0 in IDLE.
- Response routing (combinational):
  - o_ibus_rsp = i_mem_rsp & (state==GNT_I).
  - o_dbus_rsp = i_mem_rsp & (state==GNT_D).
  - o_ibus_data = i_mem_rdata when o_ibus_rsp, else 0; same rule for o_dbus_rdata.
- starve_cnt:
  - On each dbus grant while i_ibus_req=1: +1, saturating at STARVE_MAX.
  - On each ibus grant: cleared to 0.
  - Otherwise: unchanged.
- Timeout:
  - In GNT_* without i_mem_rsp: tmo_cnt +1.
  - When tmo_cnt==TIMEOUT-1 and still no rsp: next state IDLE, o_mem_req=0, o_bus_err=1 for one cycle, no rsp to the requester (it keeps req and is re-arbitrated).
  - i_mem_rsp on the same cycle as expiry: rsp wins, no error.
- Requester inputs changing mid-grant do not affect o_mem_* (latched values are used).
- o_bus_err reset value 0; registered.

Test Plan:
- Reset, then ibus_req=1 addr=0x0000_0010, memory rsp 2 cycles after o_mem_req with rdata=0x0000_0013 → o_mem_req rises 1 cycle after req, o_mem_addr=0x10, o_mem_we=0, o_ibus_rsp=1 with o_ibus_data=0x13 for exactly one cycle.
- ibus_req and dbus_req (store, addr 0x100, wdata 0xDEADBEEF, wmask 0xF) rise same cycle → dbus granted first (o_mem_we=1, addr 0x100); on its rsp, ibus granted the next edge with no IDLE cycle.
- dbus_req held continuously for 6 transactions with ibus_req high, STARVE_MAX=4 → grant order D,D,D,D,I,D; starve_cnt returns to 0 after the I grant.
- TIMEOUT=8, dbus granted, memory never responds → o_bus_err pulses once, 8 cycles after grant; o_mem_req drops; o_dbus_rsp stays 0; dbus re-granted next cycle.
- i_rst_n=0 for one cycle while in GNT_D awaiting rsp, then a stray i_mem_rsp → all outputs 0 after reset, no o_dbus_rsp/o_ibus_rsp generated, state IDLE.
- i_dbus_addr changed from 0x200 to 0x300 two cycles after grant → o_mem_addr stays 0x200 until rsp.

Source files
------------

// File: rtl/ibus_dbus_arbiter.sv
// ibus_dbus_arbiter: shares one memory port between fetch (ibus) and load/store (dbus)
module ibus_dbus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ibus_req,
  input  logic [31:0] i_ibus_addr,
  output logic [31:0] o_ibus_data,
  output logic        o_ibus_rsp,
  input  logic        i_dbus_req,
  input  logic [31:0] i_dbus_addr,
  input  logic        i_dbus_we,
  input  logic [31:0] i_dbus_wdata,
  input  logic [3:0]  i_dbus_wmask,
  output logic [31:0] o_dbus_rdata,
  output logic        o_dbus_rsp,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rsp,
  output logic        o_bus_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        we_q, we_d, err_q, err_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        busy, arb, ireq, dreq, win_i, win_d, expire;
  always_comb begin
    busy     = state_q != IDLE;
    arb      = ~busy | i_mem_rsp;
    // the completing owner is masked so it cannot re-win on its own response edge
    ireq     = i_ibus_req & (state_q != GNT_I);
    dreq     = i_dbus_req & (state_q != GNT_D);
    win_d    = arb & dreq & ~(ireq & (starve_q == 4'(STARVE_MAX)));
    win_i    = arb & ireq & ~win_d;
    expire   = busy & ~i_mem_rsp & (tmo_q == 8'(TIMEOUT - 1));
    state_d  = win_d ? GNT_D : win_i ? GNT_I : (arb | expire) ? IDLE : state_q;
    tmo_d    = (win_d | win_i | expire | ~busy) ? 8'd0 : tmo_q + 8'd1;
    starve_d = win_i ? 4'd0 : (win_d & ireq & (starve_q != 4'(STARVE_MAX))) ? starve_q + 4'd1 : starve_q;
    addr_d   = win_d ? i_dbus_addr : win_i ? i_ibus_addr : addr_q;
    we_d     = win_d ? i_dbus_we : win_i ? 1'b0 : we_q;
    wdata_d  = win_d ? i_dbus_wdata : win_i ? 32'd0 : wdata_q;
    wmask_d  = win_d ? i_dbus_wmask : win_i ? 4'd0 : wmask_q;
    err_d    = expire;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      err_q    <= err_d;
    end
  end
  assign o_mem_req    = state_q != IDLE;
  assign o_mem_addr   = addr_q;
  assign o_mem_we     = we_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_wmask  = wmask_q;
  assign o_bus_err    = err_q;
  assign o_ibus_rsp   = i_mem_rsp & (state_q == GNT_I);
  assign o_dbus_rsp   = i_mem_rsp & (state_q == GNT_D);
  assign o_ibus_data  = o_ibus_rsp ? i_mem_rdata : 32'd0;
  assign o_dbus_rdata = o_dbus_rsp ? i_mem_rdata : 32'd0;
endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// tb_ibus_dbus_arbiter: directed checks of grant order, latching, timeout and reset
module tb_ibus_dbus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ibus_req = 1'b0, dbus_req = 1'b0, dbus_we = 1'b0, mem_rsp = 1'b0;
  logic [31:0] ibus_addr = '0, dbus_addr = '0, dbus_wdata = '0, mem_rdata = '0;
  logic [3:0]  dbus_wmask = '0;
  logic [31:0] ibus_data, dbus_rdata, mem_addr, mem_wdata;
  logic        ibus_rsp, dbus_rsp, mem_req, mem_we, bus_err;
  logic [3:0]  mem_wmask;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  ibus_dbus_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ibus_req(ibus_req), .i_ibus_addr(ibus_addr), .o_ibus_data(ibus_data), .o_ibus_rsp(ibus_rsp),
    .i_dbus_req(dbus_req), .i_dbus_addr(dbus_addr), .i_dbus_we(dbus_we), .i_dbus_wdata(dbus_wdata),
    .i_dbus_wmask(dbus_wmask), .o_dbus_rdata(dbus_rdata), .o_dbus_rsp(dbus_rsp),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .o_mem_wmask(mem_wmask), .i_mem_rdata(mem_rdata), .i_mem_rsp(mem_rsp), .o_bus_err(bus_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) tick();
    #1 chk("rst_req", 32'(mem_req), 0); chk("rst_err", 32'(bus_err), 0); chk("rst_addr", mem_addr, 0);
    tick(); rst_n = 1'b1; ibus_req = 1'b1; ibus_addr = 32'h10;
    #1 chk("t1_idle_req", 32'(mem_req), 0);
    tick(); #1 chk("t1_req", 32'(mem_req), 1); chk("t1_addr", mem_addr, 32'h10); chk("t1_we", 32'(mem_we), 0);
    tick(); #1 chk("t1_norsp", 32'(ibus_rsp), 0);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h13;
    #1 chk("t1_rsp", 32'(ibus_rsp), 1); chk("t1_data", ibus_data, 32'h13); chk("t1_drsp", 32'(dbus_rsp), 0);
    tick(); mem_rsp = 1'b0; ibus_req = 1'b0;
    #1 chk("t1_rsp_once", 32'(ibus_rsp), 0); chk("t1_data0", ibus_data, 0); chk("t1_idle", 32'(mem_req), 0);
    tick(); ibus_req = 1'b1; ibus_addr = 32'h40;
    dbus_req = 1'b1; dbus_addr = 32'h100; dbus_we = 1'b1; dbus_wdata = 32'hDEADBEEF; dbus_wmask = 4'hF;
    #1 chk("t2_idle", 32'(mem_req), 0);
    tick(); #1 chk("t2_d_addr", mem_addr, 32'h100); chk("t2_d_we", 32'(mem_we), 1);
    chk("t2_d_wdata", mem_wdata, 32'hDEADBEEF); chk("t2_d_wmask", 32'(mem_wmask), 32'hF);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h55;
    #1 chk("t2_drsp", 32'(dbus_rsp), 1); chk("t2_drdata", dbus_rdata, 32'h55); chk("t2_irsp0", 32'(ibus_rsp), 0);
    tick(); mem_rsp = 1'b0; dbus_req = 1'b0;
    #1 chk("t2_i_b2b", 32'(mem_req), 1); chk("t2_i_addr", mem_addr, 32'h40); chk("t2_i_we", 32'(mem_we), 0);
    chk("t2_i_wdata", mem_wdata, 0); chk("t2_i_wmask", 32'(mem_wmask), 0);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h77;
    #1 chk("t2_irsp", 32'(ibus_rsp), 1); chk("t2_idata", ibus_data, 32'h77); chk("t2_drdata0", dbus_rdata, 0);
    tick(); mem_rsp = 1'b0; ibus_req = 1'b0;
    #1 chk("t2_idle_end", 32'(mem_req), 0);
    tick(); ibus_req = 1'b1; ibus_addr = 32'hB00;
    dbus_req = 1'b1; dbus_addr = 32'hA00; dbus_we = 1'b0; dbus_wdata = 32'h0; dbus_wmask = 4'h0;
    for (int r = 0; r < 4; r++) begin
      tick(); #1 chk("st_d_grant", mem_addr, 32'hA00); chk("st_d_req", 32'(mem_req), 1);
      repeat (6) tick();
      tick(); #1 chk("st_err_early", 32'(bus_err), 0);
      tick(); #1 chk("st_err", 32'(bus_err), 1); chk("st_err_req", 32'(mem_req), 0); chk("st_drsp0", 32'(dbus_rsp), 0);
    end
    tick(); #1 chk("st_i_grant", mem_addr, 32'hB00); chk("st_i_we", 32'(mem_we), 0);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h99;
    #1 chk("st_irsp", 32'(ibus_rsp), 1); chk("st_idata", ibus_data, 32'h99);
    tick(); mem_rsp = 1'b0; ibus_addr = 32'hB04;
    #1 chk("st_d6_grant", mem_addr, 32'hA00); chk("st_d6_req", 32'(mem_req), 1);
    repeat (6) tick();
    tick(); #1 chk("st6_err_early", 32'(bus_err), 0);
    tick(); #1 chk("st6_err", 32'(bus_err), 1);
    tick(); #1 chk("st_d7_grant", mem_addr, 32'hA00);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h5A;
    #1 chk("st_d7_rsp", 32'(dbus_rsp), 1); chk("st_d7_rdata", dbus_rdata, 32'h5A);
    tick(); mem_rsp = 1'b0; dbus_req = 1'b0;
    #1 chk("st_i8_grant", mem_addr, 32'hB04);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h3C;
    #1 chk("st_i8_rsp", 32'(ibus_rsp), 1);
    tick(); mem_rsp = 1'b0; ibus_req = 1'b0;
    #1 chk("st_idle", 32'(mem_req), 0);
    tick(); dbus_req = 1'b1; dbus_addr = 32'h200;
    tick(); #1 chk("lat_grant", mem_addr, 32'h200);
    tick();
    tick(); dbus_addr = 32'h300;
    #1 chk("lat_hold1", mem_addr, 32'h200);
    tick(); #1 chk("lat_hold2", mem_addr, 32'h200);
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h1234;
    #1 chk("lat_rsp", 32'(dbus_rsp), 1); chk("lat_hold3", mem_addr, 32'h200);
    tick(); mem_rsp = 1'b0; dbus_req = 1'b0;
    #1 chk("lat_idle", 32'(mem_req), 0);
    tick(); dbus_req = 1'b1; dbus_addr = 32'h300; dbus_we = 1'b1; dbus_wdata = 32'hCAFEF00D; dbus_wmask = 4'h3;
    tick(); #1 chk("rm_grant", 32'(mem_req), 1); chk("rm_we", 32'(mem_we), 1);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; dbus_req = 1'b0; mem_rsp = 1'b1; mem_rdata = 32'hFFFF;
    #1 chk("rm_req", 32'(mem_req), 0); chk("rm_addr", mem_addr, 0); chk("rm_we0", 32'(mem_we), 0);
    chk("rm_wdata", mem_wdata, 0); chk("rm_wmask", 32'(mem_wmask), 0); chk("rm_drsp", 32'(dbus_rsp), 0);
    chk("rm_irsp", 32'(ibus_rsp), 0); chk("rm_rdata", dbus_rdata, 0); chk("rm_err", 32'(bus_err), 0);
    tick(); mem_rsp = 1'b0;
    #1 chk("rm_idle", 32'(mem_req), 0);
    tick(); dbus_req = 1'b1; dbus_addr = 32'h400; dbus_we = 1'b0;
    tick();
    repeat (6) tick();
    tick(); mem_rsp = 1'b1; mem_rdata = 32'h42;
    #1 chk("edge_rsp", 32'(dbus_rsp), 1); chk("edge_rdata", dbus_rdata, 32'h42);
    tick(); mem_rsp = 1'b0; dbus_req = 1'b0;
    #1 chk("edge_noerr", 32'(bus_err), 0); chk("edge_idle", 32'(mem_req), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
